regfile_param: RTL and testbench

//  Parametrised CPU register file: NREGS x WIDTH storage, one write port, two

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_param_register_be.sv | 31 +++
 rtl/regfile_param.sv | 76 +++++++
 tb/tb_regfile_param.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and the byte-lane merge used by storage and bypass paths.
// Pure combinational helpers; no timing or flow control.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREGS = 32;

  // One byte lane: take the new byte when its enable is set, else keep the old one.
  function automatic logic [7:0] merge(input logic [7:0] old_b,
                                       input logic [7:0] new_b,
                                       input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/regfile_param_register_be.sv
// WIDTH-bit register with per-byte write enables, updates on the falling clock edge.
// One negedge of write latency; async active-high reset loads RESET_VAL, no backpressure.
module register_be
  import regfile_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH-1:0]   d,
  input  logic [WIDTH/8-1:0] be,
  output logic [WIDTH-1:0]   q
);

  logic [WIDTH-1:0] nxt;

  for (genvar b = 0; b < WIDTH / 8; b++) begin : g_lane
    assign nxt[8*b +: 8] = merge(q[8*b +: 8], d[8*b +: 8], be[b]);
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// NREGS x WIDTH register file: one byte-enabled negedge write port, two combinational reads.
// Reads are zero latency with optional write-to-read bypass; writes are never stalled.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               NREGS     = DEF_NREGS,
  parameter int               ZERO_REG0 = 1,
  parameter int               BYPASS    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wrenable,
  input  logic [$clog2(NREGS)-1:0]   wraddr,
  input  logic [WIDTH-1:0]           wrdata,
  input  logic [WIDTH/8-1:0]         wrbe,
  input  logic [$clog2(NREGS)-1:0]   rdaddr1,
  output logic [WIDTH-1:0]           rddata1,
  input  logic [$clog2(NREGS)-1:0]   rdaddr2,
  output logic [WIDTH-1:0]           rddata2,
  output logic [15:0]                wrcount
);

  localparam int AW = $clog2(NREGS);

  logic [WIDTH-1:0] mem [NREGS];
  logic [WIDTH-1:0] wr_merged;
  logic             wr_zero;
  logic             commit;

  // A write to the hardwired-zero entry is dropped entirely: no storage, no count, no bypass.
  assign wr_zero = (ZERO_REG0 != 0) && (wraddr == '0);
  assign commit  = wrenable && (|wrbe) && !wr_zero;

  for (genvar i = 0; i < NREGS; i++) begin : g_ent
    if (i == 0 && ZERO_REG0 != 0) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_reg
      register_be #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
      ) u_reg (
        .clk (clk),
        .rst (reset),
        .en  (commit && (wraddr == AW'(i))),
        .d   (wrdata),
        .be  (wrbe),
        .q   (mem[i])
      );
    end
  end

  // Value the written entry will hold after the coming negedge.
  for (genvar b = 0; b < WIDTH / 8; b++) begin : g_byp_lane
    assign wr_merged[8*b +: 8] = merge(mem[wraddr][8*b +: 8], wrdata[8*b +: 8], wrbe[b]);
  end

  always_comb begin
    rddata1 = mem[rdaddr1];
    rddata2 = mem[rdaddr2];
    if (BYPASS != 0 && commit) begin
      if (rdaddr1 == wraddr) rddata1 = wr_merged;
      if (rdaddr2 == wraddr) rddata2 = wr_merged;
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      wrcount <= '0;
    end else if (commit && wrcount != 16'hFFFF) begin
      wrcount <= wrcount + 16'd1;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench: two instances (defaults, and ZERO_REG0=0/BYPASS=0) share all inputs.
module tb_regfile_param;

  logic        clk = 1'b1;
  logic        reset;
  logic        wrenable;
  logic [4:0]  wraddr;
  logic [31:0] wrdata;
  logic [3:0]  wrbe;
  logic [4:0]  rdaddr1;
  logic [4:0]  rdaddr2;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic [15:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  regfile_param u_a (
    .clk(clk), .reset(reset), .wrenable(wrenable), .wraddr(wraddr), .wrdata(wrdata),
    .wrbe(wrbe), .rdaddr1(rdaddr1), .rddata1(rd1_a), .rdaddr2(rdaddr2), .rddata2(rd2_a),
    .wrcount(cnt_a)
  );

  regfile_param #(.ZERO_REG0(0), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .wrenable(wrenable), .wraddr(wraddr), .wrdata(wrdata),
    .wrbe(wrbe), .rdaddr1(rdaddr1), .rddata1(rd1_b), .rdaddr2(rdaddr2), .rddata2(rd2_b),
    .wrcount(cnt_b)
  );

  // sel: 0 a.rd1, 1 a.rd2, 2 a.wrcount, 3 b.rd1, 4 b.rd2, 5 b.wrcount
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  event smp_ev;
  int   checks   = 0;
  int   failures = 0;

  task automatic push_exp(input string n, input int sel, input logic [31:0] e);
    exp_t it;
    it.name = n;
    it.sel  = sel;
    it.exp  = e;
    sb.push_back(it);
  endtask

  task automatic sample();
    -> smp_ev;
    #1;
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    wrenable = en;
    wraddr   = a;
    wrdata   = d;
    wrbe     = be;
  endtask

  task automatic commit_edge();
    @(negedge clk);
    #1;
    wrenable = 1'b0;
    wrbe     = 4'h0;
    #1;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(smp_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.sel)
          0:       act = rd1_a;
          1:       act = rd2_a;
          2:       act = {16'h0, cnt_a};
          3:       act = rd1_b;
          4:       act = rd2_b;
          5:       act = {16'h0, cnt_b};
          default: act = 'x;
        endcase
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b1;
    set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    rdaddr1 = 5'd0;
    rdaddr2 = 5'd0;
    repeat (2) at_pos();
    reset   = 1'b0;
    rdaddr1 = 5'd5;
    rdaddr2 = 5'd7;
    #1;
    push_exp("rst_rd1_a", 0, 32'h0);
    push_exp("rst_rd2_b", 4, 32'h0);
    push_exp("rst_cnt_a", 2, 32'h0);
    push_exp("rst_cnt_b", 5, 32'h0);
    sample();

    // Full-word write to entry 5
    at_pos();
    set_wr(1'b1, 5'd5, 32'hDEADBEEF, 4'hF);
    #1;
    push_exp("full_byp_a", 0, 32'hDEADBEEF);
    push_exp("full_old_b", 3, 32'h0);
    sample();
    commit_edge();
    push_exp("full_rd_a", 0, 32'hDEADBEEF);
    push_exp("full_rd_b", 3, 32'hDEADBEEF);
    push_exp("full_cnt_a", 2, 32'd1);
    push_exp("full_cnt_b", 5, 32'd1);
    sample();

    // Byte-enable merge
    at_pos();
    set_wr(1'b1, 5'd5, 32'h11223344, 4'b0101);
    #1;
    push_exp("be_byp_a", 0, 32'hDE22BE44);
    push_exp("be_old_b", 3, 32'hDEADBEEF);
    sample();
    commit_edge();
    push_exp("be_rd_a", 0, 32'hDE22BE44);
    push_exp("be_rd_b", 3, 32'hDE22BE44);
    push_exp("be_cnt_a", 2, 32'd2);
    sample();

    // wrbe=0 is a no-op and is not bypassed
    at_pos();
    set_wr(1'b1, 5'd5, 32'h00000000, 4'h0);
    #1;
    push_exp("be0_byp_a", 0, 32'hDE22BE44);
    sample();
    commit_edge();
    push_exp("be0_rd_b", 3, 32'hDE22BE44);
    push_exp("be0_cnt_a", 2, 32'd2);
    push_exp("be0_cnt_b", 5, 32'd2);
    sample();

    // Entry 0: hardwired zero on a, ordinary register on b
    at_pos();
    rdaddr1 = 5'd0;
    set_wr(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF);
    #1;
    push_exp("z_byp_a", 0, 32'h0);
    push_exp("z_old_b", 3, 32'h0);
    sample();
    commit_edge();
    push_exp("z_rd_a", 0, 32'h0);
    push_exp("z_rd_b", 3, 32'hFFFFFFFF);
    push_exp("z_cnt_a", 2, 32'd2);
    push_exp("z_cnt_b", 5, 32'd3);
    sample();

    // Bypass vs. no bypass on entry 7, both ports on the same address
    at_pos();
    rdaddr1 = 5'd7;
    set_wr(1'b1, 5'd7, 32'hA5A5A5A5, 4'hF);
    #1;
    push_exp("byp_rd2_a", 1, 32'hA5A5A5A5);
    push_exp("byp_rd1_a", 0, 32'hA5A5A5A5);
    push_exp("nobyp_rd2_b", 4, 32'h0);
    push_exp("nobyp_rd1_b", 3, 32'h0);
    sample();
    commit_edge();
    push_exp("byp_post_a", 1, 32'hA5A5A5A5);
    push_exp("nobyp_post_b", 4, 32'hA5A5A5A5);
    push_exp("byp_cnt_a", 2, 32'd3);
    push_exp("byp_cnt_b", 5, 32'd4);
    sample();

    // Reset asserted mid-cycle clears everything without a clock edge
    at_pos();
    rdaddr1 = 5'd5;
    #2;
    reset = 1'b1;
    #1;
    push_exp("mrst_rd1_a", 0, 32'h0);
    push_exp("mrst_rd1_b", 3, 32'h0);
    push_exp("mrst_rd2_a", 1, 32'h0);
    push_exp("mrst_rd2_b", 4, 32'h0);
    push_exp("mrst_cnt_a", 2, 32'h0);
    push_exp("mrst_cnt_b", 5, 32'h0);
    sample();
    at_pos();
    reset = 1'b0;

    // Reset arriving on the same edge as a write wins
    at_pos();
    rdaddr1 = 5'd3;
    set_wr(1'b1, 5'd3, 32'h12345678, 4'hF);
    @(negedge clk);
    reset = 1'b1;
    #1;
    wrenable = 1'b0;
    wrbe     = 4'h0;
    #1;
    push_exp("rw_rd_a", 0, 32'h0);
    push_exp("rw_rd_b", 3, 32'h0);
    push_exp("rw_cnt_b", 5, 32'h0);
    sample();
    at_pos();
    reset = 1'b0;
    #1;
    push_exp("rw_after_a", 0, 32'h0);
    push_exp("rw_after_b", 3, 32'h0);
    sample();

    // Saturating write counter
    at_pos();
    rdaddr1 = 5'd1;
    set_wr(1'b1, 5'd1, 32'h5A5A0001, 4'hF);
    repeat (65534) @(negedge clk);
    #1;
    push_exp("sat_fffe_a", 2, 32'h0000FFFE);
    push_exp("sat_fffe_b", 5, 32'h0000FFFE);
    sample();
    @(negedge clk);
    #1;
    push_exp("sat_ffff_a", 2, 32'h0000FFFF);
    sample();
    repeat (3) @(negedge clk);
    #1;
    wrenable = 1'b0;
    wrbe     = 4'h0;
    #1;
    push_exp("sat_hold_a", 2, 32'h0000FFFF);
    push_exp("sat_hold_b", 5, 32'h0000FFFF);
    push_exp("sat_data_a", 0, 32'h5A5A0001);
    push_exp("sat_data_b", 3, 32'h5A5A0001);
    sample();

    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
